// File: rtl/peripheral_axi4_pkg.sv
// Shared AHB/AXI peripheral definitions: bus encodings and the slave-arbiter state type.
package peripheral_axi4_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWNED  = 2'b01,
    PARKED = 2'b10
  } arb_state_t;

endpackage

// File: rtl/peripheral_msi_arb_rr_pick.sv
// Combinational winner select: highest priority among requesters, ties broken
// round-robin starting just after last_idx.
module peripheral_msi_arb_rr_pick #(
  parameter int MASTERS   = 5,
  parameter int PRIO_BITS = 3,
  localparam int IW       = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0]           req,
  input  logic [MASTERS*PRIO_BITS-1:0] prio,
  input  logic [IW-1:0]                last_idx,
  output logic [MASTERS-1:0]           winner_onehot,
  output logic [IW-1:0]                winner_idx,
  output logic                         any
);

  logic [PRIO_BITS-1:0] max_prio;
  logic [MASTERS-1:0]   cand;
  logic                 found;

  always_comb begin
    max_prio = '0;
    for (int i = 0; i < MASTERS; i++)
      if (req[i] && (prio[i*PRIO_BITS +: PRIO_BITS] > max_prio))
        max_prio = prio[i*PRIO_BITS +: PRIO_BITS];

    cand = '0;
    for (int i = 0; i < MASTERS; i++)
      cand[i] = req[i] && (prio[i*PRIO_BITS +: PRIO_BITS] == max_prio);

    // Two passes give the wrap order: indices above last_idx first, then 0..last_idx.
    winner_onehot = '0;
    winner_idx    = '0;
    found         = 1'b0;
    for (int i = 0; i < MASTERS; i++)
      if (!found && cand[i] && (i > int'(last_idx))) begin
        found            = 1'b1;
        winner_onehot[i] = 1'b1;
        winner_idx       = IW'(i);
      end
    for (int i = 0; i < MASTERS; i++)
      if (!found && cand[i] && (i <= int'(last_idx))) begin
        found            = 1'b1;
        winner_onehot[i] = 1'b1;
        winner_idx       = IW'(i);
      end
  end

  assign any = |req;

endmodule

// File: rtl/peripheral_msi_slave_arbiter_axi4.sv
// Per-slave arbiter for the multi-master interconnect: registered one-hot grant with
// priority + round-robin selection, bus parking and lock/wait-state hold.
//
// state  | meaning
// IDLE   | no grant issued since reset
// OWNED  | holder granted and requesting
// PARKED | holder retains grant but is not requesting
module peripheral_msi_slave_arbiter_axi4 #(
  parameter int MASTERS   = 5,
  parameter int PRIO_BITS = 3
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [MASTERS-1:0]           mst_req,
  input  logic [MASTERS*PRIO_BITS-1:0] mst_priority,
  input  logic [MASTERS-1:0]           mst_can_switch,
  input  logic                         slv_HREADY,
  output logic [MASTERS-1:0]           master_granted,
  output logic [$clog2(MASTERS)-1:0]   grant_sel,
  output logic                         grant_valid
);
  import peripheral_axi4_pkg::*;

  localparam int IW = $clog2(MASTERS);

  arb_state_t         state;
  logic [IW-1:0]      last_idx;
  logic [MASTERS-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               arb_ev;

  peripheral_msi_arb_rr_pick #(
    .MASTERS   (MASTERS),
    .PRIO_BITS (PRIO_BITS)
  ) u_pick (
    .req           (mst_req),
    .prio          (mst_priority),
    .last_idx      (last_idx),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .any           (pick_any)
  );

  // Holder's can_switch is picked out through the one-hot grant, avoiding a wide index.
  assign arb_ev = slv_HREADY &&
                  ((state != OWNED) || (|(mst_can_switch & master_granted)));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state          <= IDLE;
      master_granted <= '0;
      grant_sel      <= '0;
      grant_valid    <= 1'b0;
      last_idx       <= IW'(MASTERS - 1);
    end else if (arb_ev) begin
      if (pick_any) begin
        state          <= OWNED;
        master_granted <= pick_onehot;
        grant_sel      <= pick_idx;
        last_idx       <= pick_idx;
        grant_valid    <= 1'b1;
      end else if (state == OWNED) begin
        state       <= PARKED;
        grant_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_msi_slave_arbiter_axi4.sv
// Directed bench for the slave arbiter: reset, tie, priority, lock, wait, park and wrap.
module tb_peripheral_msi_slave_arbiter_axi4;

  logic        HCLK;
  logic        HRESET;
  logic [4:0]  mst_req;
  logic [14:0] mst_priority;
  logic [4:0]  mst_can_switch;
  logic        slv_HREADY;
  logic [4:0]  master_granted;
  logic [2:0]  grant_sel;
  logic        grant_valid;

  logic [2:0]  pr [5];
  int          checks;
  int          passed;

  assign mst_priority = {pr[4], pr[3], pr[2], pr[1], pr[0]};

  peripheral_msi_slave_arbiter_axi4 #(.MASTERS(5), .PRIO_BITS(3)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .mst_req        (mst_req),
    .mst_priority   (mst_priority),
    .mst_can_switch (mst_can_switch),
    .slv_HREADY     (slv_HREADY),
    .master_granted (master_granted),
    .grant_sel      (grant_sel),
    .grant_valid    (grant_valid)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_prio(input logic [2:0] p4, p3, p2, p1, p0);
    pr[4] = p4; pr[3] = p3; pr[2] = p2; pr[1] = p1; pr[0] = p0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; mst_req = 5'b00000; mst_can_switch = 5'b00000; slv_HREADY = 1'b1;
    set_prio(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    tick(); tick();
    checks++; if (master_granted !== 5'b00000) $display("FAIL reset_granted got %b want %b", master_granted, 5'b00000); else passed++;
    checks++; if (grant_sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", grant_sel); else passed++;
    checks++; if (grant_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", grant_valid); else passed++;
    HRESET = 1'b0;
    tick();
    checks++; if (master_granted !== 5'b00000 || grant_valid !== 1'b0) $display("FAIL idle_stay got %b/%b want 00000/0", master_granted, grant_valid); else passed++;
  endtask

  task automatic test_tie();
    mst_req = 5'b00110; set_prio(3'd3, 3'd3, 3'd3, 3'd3, 3'd3);
    #2;
    checks++; if (master_granted !== 5'b00000) $display("FAIL tie_no_comb got %b want 00000", master_granted); else passed++;
    tick();
    checks++; if (master_granted !== 5'b00010) $display("FAIL tie_granted got %b want 00010", master_granted); else passed++;
    checks++; if (grant_sel !== 3'd1) $display("FAIL tie_sel got %0d want 1", grant_sel); else passed++;
    checks++; if (grant_valid !== 1'b1) $display("FAIL tie_valid got %b want 1", grant_valid); else passed++;
  endtask

  task automatic test_priority();
    mst_req = 5'b10010; mst_can_switch = 5'b00010;
    set_prio(3'd5, 3'd0, 3'd0, 3'd2, 3'd0);
    tick();
    checks++; if (master_granted !== 5'b10000) $display("FAIL prio_granted got %b want 10000", master_granted); else passed++;
    checks++; if (grant_sel !== 3'd4) $display("FAIL prio_sel got %0d want 4", grant_sel); else passed++;
  endtask

  task automatic test_lock();
    mst_req = 5'b10001; mst_can_switch = 5'b00000;
    set_prio(3'd5, 3'd0, 3'd0, 3'd0, 3'd7);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (master_granted !== 5'b10000) $display("FAIL lock_hold_%0d got %b want 10000", c, master_granted); else passed++;
    end
    mst_can_switch = 5'b10000;
    #2;
    checks++; if (master_granted !== 5'b10000) $display("FAIL lock_release_early got %b want 10000", master_granted); else passed++;
    tick();
    checks++; if (master_granted !== 5'b00001) $display("FAIL lock_release got %b want 00001", master_granted); else passed++;
    checks++; if (grant_sel !== 3'd0) $display("FAIL lock_release_sel got %0d want 0", grant_sel); else passed++;
  endtask

  task automatic test_wait();
    mst_req = 5'b00011; mst_can_switch = 5'b00001; slv_HREADY = 1'b0;
    set_prio(3'd0, 3'd0, 3'd0, 3'd6, 3'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (master_granted !== 5'b00001) $display("FAIL wait_hold_%0d got %b want 00001", c, master_granted); else passed++;
    end
    slv_HREADY = 1'b1;
    tick();
    checks++; if (master_granted !== 5'b00010) $display("FAIL wait_switch got %b want 00010", master_granted); else passed++;
    checks++; if (grant_sel !== 3'd1) $display("FAIL wait_switch_sel got %0d want 1", grant_sel); else passed++;
  endtask

  task automatic test_park();
    mst_req = 5'b00000; mst_can_switch = 5'b00010;
    tick();
    checks++; if (master_granted !== 5'b00010) $display("FAIL park_granted got %b want 00010", master_granted); else passed++;
    checks++; if (grant_valid !== 1'b0) $display("FAIL park_valid got %b want 0", grant_valid); else passed++;
    tick();
    checks++; if (master_granted !== 5'b00010 || grant_valid !== 1'b0) $display("FAIL park_stay got %b/%b want 00010/0", master_granted, grant_valid); else passed++;
    mst_req = 5'b00010;
    tick();
    checks++; if (master_granted !== 5'b00010) $display("FAIL resume_granted got %b want 00010", master_granted); else passed++;
    checks++; if (grant_valid !== 1'b1) $display("FAIL resume_valid got %b want 1", grant_valid); else passed++;
  endtask

  task automatic test_wrap();
    mst_req = 5'b10000; set_prio(3'd2, 3'd2, 3'd2, 3'd2, 3'd2);
    tick();
    checks++; if (master_granted !== 5'b10000) $display("FAIL wrap_setup got %b want 10000", master_granted); else passed++;
    mst_req = 5'b10001; mst_can_switch = 5'b10000;
    tick();
    checks++; if (master_granted !== 5'b00001) $display("FAIL wrap_granted got %b want 00001", master_granted); else passed++;
    checks++; if (grant_sel !== 3'd0) $display("FAIL wrap_sel got %0d want 0", grant_sel); else passed++;
    mst_req = 5'b00001; mst_can_switch = 5'b00001;
    tick();
    checks++; if (master_granted !== 5'b00001 || grant_valid !== 1'b1) $display("FAIL holder_keeps got %b/%b want 00001/1", master_granted, grant_valid); else passed++;
  endtask

  task automatic test_reset_override();
    mst_req = 5'b00100; mst_can_switch = 5'b11111; HRESET = 1'b1;
    tick();
    checks++; if (master_granted !== 5'b00000) $display("FAIL rst_ovr_granted got %b want 00000", master_granted); else passed++;
    checks++; if (grant_valid !== 1'b0 || grant_sel !== 3'd0) $display("FAIL rst_ovr_valid_sel got %b/%0d want 0/0", grant_valid, grant_sel); else passed++;
    HRESET = 1'b0; mst_req = 5'b10001;
    tick();
    checks++; if (master_granted !== 5'b00001) $display("FAIL rst_ptr got %b want 00001", master_granted); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_tie();
    test_priority();
    test_lock();
    test_wait();
    test_park();
    test_wrap();
    test_reset_override();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
